// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 target with bus-mapped RX/TX holding registers, status and interrupt
`ifndef LEN
`define LEN 16
`endif
module spi_slave_port #(
  parameter logic [7:0] TX_IDLE     = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            en_i,
  input  logic            en_cs,
  input  logic [`LEN-1:0] addr_i,
  inout  wire  [`LEN-1:0] data,
  input  logic            SCLK,
  input  logic            SS_N,
  input  logic            MOSI,
  output logic            MISO,
  output logic            MISO_OE,
  output logic            O_INT
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int N = SYNC_STAGES;
  state_t state;
  // Sync chains are left unreset so a reset mid-frame cannot fake an SS_N falling edge
  logic [N:0]   sclk_s, ss_s;
  logic [N-1:0] mosi_s;
  logic [7:0]   shift_rx, shift_tx, rx_data, tx_hold, status, rd_val, rx_byte, tx_next;
  logic [3:0]   bit_cnt;
  logic         rx_valid, tx_full, overrun, rd0_d;
  logic         sclk_rise, sclk_fall, ss_fall, ss_rise, busy;
  logic         wr, rd, rd0, pop, wr_tx, clr_ovr, byte_done;
  logic         unused_ok;
  always_ff @(posedge clk_in) begin
    sclk_s <= {sclk_s[N-1:0], SCLK};
    ss_s   <= {ss_s[N-1:0], SS_N};
    mosi_s <= {mosi_s[N-2:0], MOSI};
  end
  assign sclk_rise = sclk_s[N-1] & ~sclk_s[N];
  assign sclk_fall = ~sclk_s[N-1] & sclk_s[N];
  assign ss_fall   = ~ss_s[N-1] & ss_s[N];
  assign ss_rise   = ss_s[N-1] & ~ss_s[N];
  assign wr        = en_cs & en_i;
  assign rd        = en_cs & ~en_i;
  assign rd0       = rd & (addr_i[1:0] == 2'd0);
  assign pop       = rd0 & ~rd0_d;
  assign wr_tx     = wr & (addr_i[1:0] == 2'd0);
  assign clr_ovr   = wr & (addr_i[1:0] == 2'd2) & data[0];
  assign byte_done = (state == ACTIVE) & ~ss_rise & sclk_rise & (bit_cnt == 4'd7);
  assign rx_byte   = {shift_rx[6:0], mosi_s[N-1]};
  assign tx_next   = tx_full ? tx_hold : TX_IDLE;
  assign busy      = (state == ACTIVE) & (bit_cnt != 4'd0);
  assign status    = {3'b0, ~ss_s[N-1], busy, overrun, tx_full, rx_valid};
  assign rd_val    = (addr_i[1:0] == 2'd0) ? rx_data : (addr_i[1:0] == 2'd1) ? status : 8'h00;
  assign data      = rd ? {{(`LEN-8){1'b0}}, rd_val} : {`LEN{1'bz}};
  assign MISO_OE   = (state == ACTIVE);
  assign MISO      = MISO_OE & shift_tx[7];
  assign O_INT     = rx_valid | overrun;
  assign unused_ok = ^{addr_i[`LEN-1:2], data[`LEN-1:8]};
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state    <= IDLE;
      shift_rx <= 8'h00;
      shift_tx <= 8'h00;
      rx_data  <= 8'h00;
      tx_hold  <= 8'h00;
      bit_cnt  <= 4'd0;
      rx_valid <= 1'b0;
      tx_full  <= 1'b0;
      overrun  <= 1'b0;
      rd0_d    <= 1'b0;
    end else begin
      rd0_d <= rd0;
      if (wr_tx) tx_hold <= data[7:0];
      if (clr_ovr) overrun <= 1'b0;
      // A pop in the same cycle frees the holding register for the new byte
      if (byte_done) begin
        if (!rx_valid || pop) begin
          rx_data  <= rx_byte;
          rx_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (pop) rx_valid <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall) begin
          state    <= ACTIVE;
          bit_cnt  <= 4'd0;
          shift_tx <= tx_next;
          tx_full  <= wr_tx;
        end else if (wr_tx) tx_full <= 1'b1;
      end else if (ss_rise) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        if (wr_tx) tx_full <= 1'b1;
      end else if (sclk_rise) begin
        shift_rx <= rx_byte;
        bit_cnt  <= bit_cnt + 4'd1;
        if (wr_tx) tx_full <= 1'b1;
      end else if (sclk_fall && bit_cnt == 4'd8) begin
        bit_cnt  <= 4'd0;
        shift_tx <= tx_next;
        tx_full  <= wr_tx;
      end else begin
        if (sclk_fall && bit_cnt != 4'd0) shift_tx <= shift_tx << 1;
        if (wr_tx) tx_full <= 1'b1;
      end
    end
  end
endmodule
